// File: rtl/dmi_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmi_responder
// Description : Debug-module end of the DMI request/response channel. Takes
//               one DTM request at a time, decodes it against a small debug
//               register bank (data0, data1, dmcontrol, dmstatus,
//               abstractcs) and returns the response after a programmable
//               number of wait cycles. Drives dmactive/ndmreset outward.
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_responder #(
    parameter int          RESP_LATENCY     = 2,
    parameter logic [31:0] DMSTATUS_VALUE   = 32'h0000_0C82,
    parameter logic [31:0] ABSTRACTCS_VALUE = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        debug_req_valid,
    output logic        debug_req_ready,
    input  logic [6:0]  debug_req_addr,
    input  logic [31:0] debug_req_data,
    input  logic [1:0]  debug_req_op,
    output logic        debug_resp_valid,
    input  logic        debug_resp_ready,
    output logic [31:0] debug_resp_data,
    output logic [1:0]  debug_resp_resp,
    output logic        dmactive,
    output logic        ndmreset
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [1:0] c_op_nop   = 2'd0;
    localparam logic [1:0] c_op_read  = 2'd1;
    localparam logic [1:0] c_op_write = 2'd2;

    localparam logic [1:0] c_resp_ok   = 2'd0;
    localparam logic [1:0] c_resp_fail = 2'd2;

    localparam logic [6:0] c_addr_data0      = 7'h04;
    localparam logic [6:0] c_addr_data1      = 7'h05;
    localparam logic [6:0] c_addr_dmcontrol  = 7'h10;
    localparam logic [6:0] c_addr_dmstatus   = 7'h11;
    localparam logic [6:0] c_addr_abstractcs = 7'h16;

    // With zero latency the WAIT state is skipped entirely, so the counter
    // preload value only matters for non-zero latencies.
    localparam bit         c_zero_latency = (RESP_LATENCY == 0);
    localparam logic [3:0] c_cnt_init     = (RESP_LATENCY > 0) ? 4'(RESP_LATENCY - 1) : 4'd0;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_cnt;

    logic [31:0] r_data0;
    logic [31:0] r_data1;
    logic        r_dmactive;
    logic        r_ndmreset;
    logic [31:0] r_resp_data;
    logic [1:0]  r_resp_code;

    logic        w_accept;
    logic        w_addr_ok;
    logic [31:0] w_rd_data;
    logic [31:0] w_resp_data;
    logic [1:0]  w_resp_code;
    logic        w_wr_data0;
    logic        w_wr_data1;
    logic        w_wr_dmctl;

    // A request is taken only while idle; ready is a pure function of state.
    assign w_accept = debug_req_valid & (r_state == c_st_idle);

    // ------------------------------------------------------------------
    // Address decode: current read value of the addressed register
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = 32'd0;
        w_addr_ok = 1'b1;
        case (debug_req_addr)
            c_addr_data0:      w_rd_data = r_data0;
            c_addr_data1:      w_rd_data = r_data1;
            c_addr_dmcontrol:  w_rd_data = {30'd0, r_ndmreset, r_dmactive};
            c_addr_dmstatus:   w_rd_data = DMSTATUS_VALUE;
            c_addr_abstractcs: w_rd_data = ABSTRACTCS_VALUE;
            default:           w_addr_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Op decode: response payload and write enables for this request
    // ------------------------------------------------------------------
    always_comb begin
        w_resp_data = 32'd0;
        w_resp_code = c_resp_ok;
        w_wr_data0  = 1'b0;
        w_wr_data1  = 1'b0;
        w_wr_dmctl  = 1'b0;
        case (debug_req_op)
            c_op_nop: begin
                // no data, no side effect, still pays the full latency
            end
            c_op_read: begin
                if (w_addr_ok) begin
                    w_resp_data = w_rd_data;
                end else begin
                    w_resp_code = c_resp_fail;
                end
            end
            c_op_write: begin
                // dmstatus/abstractcs accept writes silently
                if (w_addr_ok) begin
                    w_wr_data0 = (debug_req_addr == c_addr_data0);
                    w_wr_data1 = (debug_req_addr == c_addr_data1);
                    w_wr_dmctl = (debug_req_addr == c_addr_dmcontrol);
                end else begin
                    w_resp_code = c_resp_fail;
                end
            end
            default: begin
                w_resp_code = c_resp_fail;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_next = c_zero_latency ? c_st_resp : c_st_wait;
                end
            end
            c_st_wait: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = c_st_resp;
                end
            end
            c_st_resp: begin
                if (debug_resp_ready) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs: handshake flags follow the state directly
    // ------------------------------------------------------------------
    always_comb begin
        debug_req_ready  = 1'b0;
        debug_resp_valid = 1'b0;
        case (r_state)
            c_st_idle: debug_req_ready  = 1'b1;
            c_st_resp: debug_resp_valid = 1'b1;
            default: begin
                debug_req_ready  = 1'b0;
                debug_resp_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counter: preloaded on acceptance, counts down while waiting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_cnt_init;
        end else if ((r_state == c_st_wait) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Register bank and response latch; everything commits on acceptance,
    // so a read reports the value seen at that edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data0     <= 32'd0;
            r_data1     <= 32'd0;
            r_dmactive  <= 1'b0;
            r_ndmreset  <= 1'b0;
            r_resp_data <= 32'd0;
            r_resp_code <= c_resp_ok;
        end else if (w_accept) begin
            r_resp_data <= w_resp_data;
            r_resp_code <= w_resp_code;
            if (w_wr_data0) begin
                r_data0 <= debug_req_data;
            end
            if (w_wr_data1) begin
                r_data1 <= debug_req_data;
            end
            if (w_wr_dmctl) begin
                r_dmactive <= debug_req_data[0];
                if (debug_req_data[0]) begin
                    r_ndmreset <= debug_req_data[1];
                end else begin
                    // dropping dmactive resets the debug module state
                    r_ndmreset <= 1'b0;
                    r_data0    <= 32'd0;
                    r_data1    <= 32'd0;
                end
            end
        end
    end

    assign debug_resp_data = r_resp_data;
    assign debug_resp_resp = r_resp_code;
    assign dmactive        = r_dmactive;
    assign ndmreset        = r_ndmreset;

endmodule
`default_nettype wire
